// File: rtl/sram_fifo_ctrl_if.sv
// Bundles the producer, consumer and primitive-side signals of the FIFO
// sequencer. The slave modport is the controller's view; master is the
// surrounding logic (producer, consumer and the FIFO_SYNC primitive).
interface sram_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 36,
  parameter int DEPTH      = 1024
);
  localparam int CNT_W = $clog2(DEPTH + 3);

  logic                  flush_i;
  logic                  init_done_o;
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [DATA_WIDTH-1:0] in_data_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [DATA_WIDTH-1:0] out_data_o;
  logic [CNT_W-1:0]      usage_o;
  logic                  fifo_rst_o;
  logic                  fifo_wren_o;
  logic [DATA_WIDTH-1:0] fifo_di_o;
  logic                  fifo_rden_o;
  logic [DATA_WIDTH-1:0] fifo_do_i;
  logic                  fifo_full_i;
  logic                  fifo_empty_i;

  modport slave (
    input  flush_i, in_valid_i, in_data_i, out_ready_i,
           fifo_do_i, fifo_full_i, fifo_empty_i,
    output init_done_o, in_ready_o, out_valid_o, out_data_o, usage_o,
           fifo_rst_o, fifo_wren_o, fifo_di_o, fifo_rden_o
  );

  modport master (
    output flush_i, in_valid_i, in_data_i, out_ready_i,
           fifo_do_i, fifo_full_i, fifo_empty_i,
    input  init_done_o, in_ready_o, out_valid_o, out_data_o, usage_o,
           fifo_rst_o, fifo_wren_o, fifo_di_o, fifo_rden_o
  );
endinterface

// File: rtl/sram_fifo_ctrl.sv
// Reset sequencer and first-word-fall-through adapter for a BRAM FIFO_SYNC
// primitive with one cycle of read latency (DO_REG=0).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RST_HOLD | primitive RST held high for RST_CYCLES cycles
// RST_WAIT | RST released, enables kept low for WAIT_CYCLES cycles
// RUN      | normal operation, writes and prefetch reads allowed
module sram_fifo_ctrl #(
  parameter  int DATA_WIDTH  = 36,
  parameter  int DEPTH       = 1024,
  parameter  int RST_CYCLES  = 5,
  parameter  int WAIT_CYCLES = 4,
  localparam int CNT_W       = $clog2(DEPTH + 3)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  sram_fifo_ctrl_if.slave   bus
);

  localparam int TMR_MAX = (RST_CYCLES > WAIT_CYCLES) ? RST_CYCLES : WAIT_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] RST_LAST  = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] WAIT_LAST = TMR_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {RST_HOLD, RST_WAIT, RUN} state_e;

  state_e                state;
  logic [TMR_W-1:0]      tmr;
  logic                  rst_q;
  logic                  run_q;

  logic [1:0]            skid_cnt;
  logic [DATA_WIDTH-1:0] skid_q0;
  logic [DATA_WIDTH-1:0] skid_q1;
  logic                  inflight;
  logic [CNT_W-1:0]      usage_q;

  logic                  in_ready;
  logic                  in_hs;
  logic                  pop;
  logic                  rden;
  logic [2:0]            held;

  // Sequencer: flush restarts the reset sequence from any state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= RST_HOLD;
      tmr   <= '0;
      rst_q <= 1'b1;
      run_q <= 1'b0;
    end else if (bus.flush_i) begin
      state <= RST_HOLD;
      tmr   <= '0;
      rst_q <= 1'b1;
      run_q <= 1'b0;
    end else begin
      case (state)
        RST_HOLD: begin
          if (tmr == RST_LAST) begin
            state <= RST_WAIT;
            tmr   <= '0;
            rst_q <= 1'b0;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        RST_WAIT: begin
          if (tmr == WAIT_LAST) begin
            state <= RUN;
            tmr   <= '0;
            run_q <= 1'b1;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        RUN: ;
        default: begin
          state <= RST_HOLD;
          tmr   <= '0;
          rst_q <= 1'b1;
          run_q <= 1'b0;
        end
      endcase
    end
  end

  // Enable gating: the primitive never sees a write when full or a read when
  // empty; prefetch stops once the skid plus the in-flight read hold two.
  always_comb begin
    in_ready = run_q & ~bus.fifo_full_i & ~bus.flush_i;
    in_hs    = bus.in_valid_i & in_ready;
    pop      = (skid_cnt != 2'd0) & bus.out_ready_i;
    held     = {1'b0, skid_cnt} + {2'b00, inflight} - {2'b00, pop};
    rden     = run_q & ~bus.flush_i & ~bus.fifo_empty_i & (held < 3'd2);
  end

  // Skid buffer: captures the primitive's DO one cycle after each read.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      skid_cnt <= 2'd0;
      skid_q0  <= '0;
      skid_q1  <= '0;
      inflight <= 1'b0;
    end else if (bus.flush_i) begin
      skid_cnt <= 2'd0;
      skid_q0  <= '0;
      skid_q1  <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= rden;
      case ({inflight, pop})
        2'b10: begin
          if (skid_cnt == 2'd0) skid_q0 <= bus.fifo_do_i;
          else                  skid_q1 <= bus.fifo_do_i;
          skid_cnt <= skid_cnt + 2'd1;
        end
        2'b01: begin
          skid_q0  <= skid_q1;
          skid_cnt <= skid_cnt - 2'd1;
        end
        2'b11: begin
          if (skid_cnt == 2'd1) begin
            skid_q0 <= bus.fifo_do_i;
          end else begin
            skid_q0 <= skid_q1;
            skid_q1 <= bus.fifo_do_i;
          end
        end
        default: ;
      endcase
    end
  end

  // Occupancy: primitive contents plus in-flight read plus skid entries.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      usage_q <= '0;
    end else if (bus.flush_i) begin
      usage_q <= '0;
    end else begin
      case ({in_hs, pop})
        2'b10:   usage_q <= usage_q + CNT_W'(1);
        2'b01:   usage_q <= usage_q - CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign bus.init_done_o = run_q;
  assign bus.fifo_rst_o  = rst_q;
  assign bus.in_ready_o  = in_ready;
  assign bus.fifo_wren_o = in_hs;
  assign bus.fifo_di_o   = bus.in_data_i;
  assign bus.fifo_rden_o = rden;
  assign bus.out_valid_o = (skid_cnt != 2'd0);
  assign bus.out_data_o  = skid_q0;
  assign bus.usage_o     = usage_q;

  skid_bound_a: assert property (@(posedge clk_i) disable iff (!rst_ni) skid_cnt <= 2'd2);

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Bench for sram_fifo_ctrl with a behavioural FIFO_SYNC model (one cycle
// read latency, flags derived from the registered occupancy).
module tb_sram_fifo_ctrl;
  localparam int DW    = 36;
  localparam int DEPTH = 1024;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_fifo_ctrl_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  sram_fifo_ctrl #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .RST_CYCLES (5),
    .WAIT_CYCLES(4)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  // Primitive model
  logic [DW-1:0] mem [DEPTH];
  int pcnt = 0;
  int wp   = 0;
  int rp   = 0;

  assign bus.fifo_empty_i = (pcnt == 0);
  assign bus.fifo_full_i  = (pcnt == DEPTH);

  always @(posedge clk) begin
    if (bus.fifo_rst_o) begin
      pcnt <= 0;
      wp   <= 0;
      rp   <= 0;
    end else begin
      if (bus.fifo_wren_o && pcnt < DEPTH) begin
        mem[wp] <= bus.fifo_di_o;
        wp      <= (wp + 1) % DEPTH;
      end
      if (bus.fifo_rden_o && pcnt > 0) begin
        bus.fifo_do_i <= mem[rp];
        rp            <= (rp + 1) % DEPTH;
      end
      pcnt <= pcnt + ((bus.fifo_wren_o && pcnt < DEPTH) ? 1 : 0)
                   - ((bus.fifo_rden_o && pcnt > 0) ? 1 : 0);
    end
  end

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] q [$];
  int mcount = 0;
  int acc    = 0;
  int pops   = 0;
  logic last_ir, last_ov, last_rst, last_done;

  typedef struct {
    logic valid;
    logic exp_rst;
    logic exp_done;
    logic exp_ready;
    logic exp_wren;
  } pu_vec_t;
  pu_vec_t tbl [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic inv();
    checks++;
    if ((bus.fifo_rden_o && bus.fifo_empty_i) ||
        (bus.fifo_wren_o && (bus.fifo_full_i || !bus.init_done_o))) begin
      errors++;
      $display("FAIL enable_guard rden=%0b empty=%0b wren=%0b full=%0b done=%0b t=%0t",
               bus.fifo_rden_o, bus.fifo_empty_i, bus.fifo_wren_o, bus.fifo_full_i,
               bus.init_done_o, $time);
    end
  endtask

  // One clock cycle: drive, sample mid-cycle, update scoreboard, advance.
  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic r, input logic fl);
    logic [DW-1:0] e;
    bus.in_valid_i  = v;
    bus.in_data_i   = d;
    bus.out_ready_i = r;
    bus.flush_i     = fl;
    @(negedge clk);
    inv();
    chk("usage", 64'(bus.usage_o), 64'(mcount));
    if (bus.out_valid_o && bus.out_ready_i) begin
      pops++;
      mcount--;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_out actual=%0h required=none t=%0t", bus.out_data_o, $time);
      end else begin
        e = q.pop_front();
        chk("out_data", 64'(bus.out_data_o), 64'(e));
      end
    end
    if (bus.in_valid_i && bus.in_ready_o) begin
      q.push_back(d);
      mcount++;
      acc++;
    end
    if (fl) begin
      q.delete();
      mcount = 0;
    end
    last_ir   = bus.in_ready_o;
    last_ov   = bus.out_valid_o;
    last_rst  = bus.fifo_rst_o;
    last_done = bus.init_done_o;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_acc, t_ov, gaps, rst_hi, done_at, n;

    //              valid rst  done ready wren
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    bus.flush_i     = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.in_data_i   = '0;
    bus.out_ready_i = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_fifo_rst",  64'(bus.fifo_rst_o),  64'd1);
    chk("rst_init_done", 64'(bus.init_done_o), 64'd0);
    chk("rst_in_ready",  64'(bus.in_ready_o),  64'd0);
    chk("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
    chk("rst_out_data",  64'(bus.out_data_o),  64'd0);
    chk("rst_usage",     64'(bus.usage_o),     64'd0);
    chk("rst_wren",      64'(bus.fifo_wren_o), 64'd0);
    chk("rst_rden",      64'(bus.fifo_rden_o), 64'd0);

    // Power-up sequence, cycle 0 is the cycle of release
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus.in_valid_i = tbl[i].valid;
      bus.in_data_i  = DW'(36'h0AA);
      @(negedge clk);
      inv();
      chk($sformatf("pu%0d_fifo_rst", i),  64'(bus.fifo_rst_o),  64'(tbl[i].exp_rst));
      chk($sformatf("pu%0d_init_done", i), 64'(bus.init_done_o), 64'(tbl[i].exp_done));
      chk($sformatf("pu%0d_in_ready", i),  64'(bus.in_ready_o),  64'(tbl[i].exp_ready));
      chk($sformatf("pu%0d_wren", i),      64'(bus.fifo_wren_o), 64'(tbl[i].exp_wren));
      @(posedge clk);
      #1;
    end

    // Stream 0x1..0x10 with consumer always ready
    acc = 0; pops = 0; t_acc = -1; t_ov = -1; gaps = 0;
    for (n = 0; n < 60; n++) begin
      if (n < 16) cyc(1'b1, DW'(n + 1), 1'b1, 1'b0);
      else        cyc(1'b0, '0, 1'b1, 1'b0);
      if (acc >= 1 && t_acc < 0) t_acc = n;
      if (last_ov && t_ov < 0) t_ov = n;
      if (t_ov >= 0 && pops < 16 && !last_ov) gaps++;
      if (pops == 16 && n >= 16) break;
    end
    chk("stream_accepted", 64'(acc), 64'd16);
    chk("stream_popped", 64'(pops), 64'd16);
    chk("stream_latency", 64'(t_ov - t_acc), 64'd3);
    chk("stream_gaps", 64'(gaps), 64'd0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("stream_usage_zero", 64'(bus.usage_o), 64'd0);

    // Fill with consumer stalled
    acc = 0;
    for (n = 0; n < 1100; n++) begin
      cyc(1'b1, DW'(36'h1000 + n), 1'b0, 1'b0);
      if (!last_ir) break;
    end
    chk("fill_accepted", 64'(acc), 64'd1026);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("fill_usage", 64'(bus.usage_o), 64'd1026);
    chk("fill_in_ready", 64'(bus.in_ready_o), 64'd0);
    chk("fill_out_valid", 64'(bus.out_valid_o), 64'd1);
    chk("fill_head", 64'(bus.out_data_o), 64'h1000);

    // Drain from full
    pops = 0;
    for (n = 0; n < 1200; n++) begin
      cyc(1'b0, '0, 1'b1, 1'b0);
      if (q.size() == 0) break;
    end
    chk("drain_popped", 64'(pops), 64'd1026);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("drain_out_valid_low", 64'(last_ov), 64'd0);
    chk("drain_usage", 64'(bus.usage_o), 64'd0);

    // Flush with 20 entries held
    for (n = 0; n < 20; n++) cyc(1'b1, DW'(36'h2000 + n), 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("preflush_usage", 64'(bus.usage_o), 64'd20);
    cyc(1'b0, '0, 1'b0, 1'b1);
    rst_hi = 0; done_at = -1;
    for (n = 0; n < 12; n++) begin
      cyc(1'b0, '0, 1'b0, 1'b0);
      if (n == 0) begin
        chk("flush_out_valid", 64'(last_ov), 64'd0);
        chk("flush_fifo_rst", 64'(last_rst), 64'd1);
      end
      if (last_rst) rst_hi++;
      if (last_done && done_at < 0) done_at = n;
    end
    chk("flush_rst_cycles", 64'(rst_hi), 64'd5);
    chk("flush_done_cycle", 64'(done_at), 64'd9);
    pops = 0;
    for (n = 0; n < 4; n++) cyc(1'b1, DW'(36'h3000 + n), 1'b1, 1'b0);
    for (n = 0; n < 20 && q.size() != 0; n++) cyc(1'b0, '0, 1'b1, 1'b0);
    chk("postflush_popped", 64'(pops), 64'd4);

    // Random push/pop at 50%
    for (n = 0; n < 10000; n++)
      cyc(1'($urandom_range(0, 1)), DW'({$urandom, $urandom}), 1'($urandom_range(0, 1)), 1'b0);
    for (n = 0; n < 1100 && q.size() != 0; n++) cyc(1'b0, '0, 1'b1, 1'b0);
    chk("random_drained", 64'(q.size()), 64'd0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("random_usage_zero", 64'(bus.usage_o), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
